fsm_share_arb: RTL

- Round-robin arbiter/sequencer that shares one `fsm` instance (inputs `clk`, `a`; outputs `out1`, `out2`) between NREQ requesters.
- The winning requester gets a burst: `fsm_a` is held high for a programmed number of cycles, then low until the FSM returns to its idle output code (out1=0, out2=0).
- The winner then receives a done pulse and the arbiter re-arbitrates.
- Sits between requester logic and the `fsm` instance. It is the only driver of the fsm `a` input.

---
 rtl/fsm_share_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fsm_share_arb.sv
// rtl/fsm_share_arb.sv - arbiter sharing one fsm instance among NREQ requesters
// Optional macro FSM_SHARE_ARB_PRIO_EN: fixed priority instead of round-robin.
module fsm_share_arb #(
    parameter int NREQ     = 4,
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic                  fsm_a,
    input  logic                  fsm_out1,
    input  logic                  fsm_out2
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  cur, cur_nx;
    logic [LEN_W-1:0]  cnt, cnt_nx;
    logic [WAIT_W-1:0] wcnt, wcnt_nx;
    logic [NREQ-1:0]   gnt_nx, done_nx;
    logic              err_nx, fsm_a_nx;
    logic              found;
    logic [IDX_W-1:0]  win;
    logic [LEN_W-1:0]  win_len;
    logic              fsm_idle;

    assign fsm_idle = !fsm_out1 && !fsm_out2;

    // Scan downward so the last hit is the highest-priority candidate.
    always_comb begin : arb
        int idx;
        found = 1'b0;
        win   = cur;
        idx   = 0;
`ifdef FSM_SHARE_ARB_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
`else
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(cur) + i) % NREQ;
            if (req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
`endif
        win_len = len[int'(win)*LEN_W +: LEN_W];
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        cnt_nx   = cnt;
        wcnt_nx  = wcnt;
        gnt_nx   = gnt;
        done_nx  = '0;
        err_nx   = 1'b0;
        fsm_a_nx = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (found) begin
                    gnt_nx[win] = 1'b1;
                    cur_nx      = win;
                    cnt_nx      = win_len;
                    wcnt_nx     = '0;
                    if (win_len != '0) begin
                        state_nx = DRIVE;
                        fsm_a_nx = 1'b1;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRIVE: begin
                cnt_nx = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    state_nx = DRAIN;
                    wcnt_nx  = '0;
                end else begin
                    fsm_a_nx = 1'b1;
                end
            end
            DRAIN: begin
                if (fsm_idle || wcnt == WAIT_MAX) begin
                    state_nx     = IDLE;
                    gnt_nx       = '0;
                    done_nx[cur] = 1'b1;
                    err_nx       = !fsm_idle;
                end else begin
                    wcnt_nx = wcnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= IDX_W'(NREQ - 1);
            cnt   <= '0;
            wcnt  <= '0;
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            fsm_a <= 1'b0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            cnt   <= cnt_nx;
            wcnt  <= wcnt_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            err   <= err_nx;
            busy  <= (state_nx != IDLE);
            fsm_a <= fsm_a_nx;
        end
    end
endmodule
